// File: rtl/rv32i_memory_stage.sv
// rv32i_memory_stage: multicycle load/store stage on a req/gnt/rvalid data bus.
// Optional watchdog: define DMEM_TIMEOUT_EN to abort stalled bus transactions.
module rv32i_memory_stage #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_mem_op,
    input  logic [2:0]            i_funct3,
    input  logic [WORD_SIZE-1:0]  i_alu_result,
    input  logic [WORD_SIZE-1:0]  i_store_data,
    input  logic [4:0]            i_rd_addr,
    input  logic                  i_rd_wr,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [3:0]            o_dmem_be,
    output logic [WORD_SIZE-1:0]  o_dmem_wdata,
    input  logic                  i_dmem_gnt,
    input  logic                  i_dmem_rvalid,
    input  logic [WORD_SIZE-1:0]  i_dmem_rdata,
    output logic                  o_valid,
    output logic [WORD_SIZE-1:0]  o_rf_wr_data,
    output logic [4:0]            o_rf_wr_addr,
    output logic                  o_rf_wr_en,
    output logic                  o_misaligned,
    output logic                  o_bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    localparam logic [1:0] OP_NONE = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2;
    state_t state_q, state_d;
    logic [1:0] op_q, op_d, in_op;
    logic [2:0] f3_q, f3_d;
    logic [WORD_SIZE-1:0] res_q, res_d, sdata_q, sdata_d, ext;
    logic [4:0] rd_q, rd_d;
    logic rd_wr_q, rd_wr_d, mis_q, mis_d, err_q, err_d;
    logic in_mis, req, done;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
`ifdef DMEM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic timeout;
    assign timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif

    // decode the offered op and select/extend the load lane from the bus
    always_comb begin
        in_op  = i_mem_op == 2'd3 ? OP_NONE : i_mem_op;
        in_mis = in_op != OP_NONE && (i_funct3[1:0] == 2'b01 ? i_alu_result[0]
                                     : i_funct3[1:0] != 2'b00 && i_alu_result[1:0] != 2'b00);
        lane_b = 8'(i_dmem_rdata >> {res_q[1:0], 3'b000});
        lane_h = res_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        ext    = f3_q == 3'b000 ? {{24{lane_b[7]}}, lane_b}
               : f3_q == 3'b001 ? {{16{lane_h[15]}}, lane_h}
               : f3_q == 3'b100 ? {24'b0, lane_b}
               : f3_q == 3'b101 ? {16'b0, lane_h} : i_dmem_rdata;
    end

    // next-state and captured-operation update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        f3_d    = f3_q;
        res_d   = res_q;
        sdata_d = sdata_q;
        rd_d    = rd_q;
        rd_wr_d = rd_wr_q;
        mis_d   = mis_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (i_valid) begin
                op_d    = in_op;
                f3_d    = i_funct3;
                res_d   = i_alu_result;
                sdata_d = i_store_data;
                rd_d    = i_rd_addr;
                rd_wr_d = i_rd_wr;
                mis_d   = in_mis;
                err_d   = 1'b0;
                state_d = in_op == OP_NONE || in_mis ? DONE : REQ;
            end
            REQ: if (i_dmem_gnt) state_d = op_q == OP_LOAD ? WAIT : DONE;
            WAIT: if (i_dmem_rvalid) begin
                res_d   = ext;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
`ifdef DMEM_TIMEOUT_EN
        if (timeout && state_d == state_q && (state_q == REQ || state_q == WAIT)) begin
            state_d = DONE;
            err_d   = 1'b1;
        end
        cnt_d = (state_q == REQ || state_q == WAIT) && state_d == state_q ? cnt_q + 16'd1 : 16'd0;
`endif
    end

    // state and operation registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            f3_q    <= '0;
            res_q   <= '0;
            sdata_q <= '0;
            rd_q    <= '0;
            rd_wr_q <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            res_q   <= res_d;
            sdata_q <= sdata_d;
            rd_q    <= rd_d;
            rd_wr_q <= rd_wr_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req          = state_q == REQ;
    assign done         = state_q == DONE;
    assign o_ready      = state_q == IDLE;
    assign o_dmem_req   = req;
    assign o_dmem_we    = req && op_q == OP_STORE;
    assign o_dmem_addr  = req ? {res_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign o_dmem_be    = !req ? 4'b0000
                        : f3_q[1:0] == 2'b00 ? 4'b0001 << res_q[1:0]
                        : f3_q[1:0] == 2'b01 ? 4'b0011 << res_q[1:0] : 4'b1111;
    assign o_dmem_wdata = !o_dmem_we ? '0
                        : f3_q[1:0] == 2'b00 ? {4{sdata_q[7:0]}}
                        : f3_q[1:0] == 2'b01 ? {2{sdata_q[15:0]}} : sdata_q;
    assign o_valid      = done;
    assign o_rf_wr_en   = done && rd_wr_q && rd_q != 5'd0 && !mis_q && !err_q && op_q != OP_STORE;
    assign o_rf_wr_data = done && rd_q != 5'd0 ? res_q : '0;
    assign o_rf_wr_addr = done ? rd_q : '0;
    assign o_misaligned = done && mis_q;
`ifdef DMEM_TIMEOUT_EN
    assign o_bus_err    = done && err_q;
`else
    assign o_bus_err    = 1'b0;
`endif
endmodule

// File: tb/tb_rv32i_memory_stage.sv
// tb_rv32i_memory_stage: randomized scoreboard bench for the memory stage
module tb_rv32i_memory_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst, i_valid, o_ready, i_rd_wr, o_dmem_req, o_dmem_we;
    logic [1:0]  i_mem_op;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result, i_store_data, o_dmem_addr, o_dmem_wdata, i_dmem_rdata, o_rf_wr_data;
    logic [4:0]  i_rd_addr, o_rf_wr_addr;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt, i_dmem_rvalid, o_valid, o_rf_wr_en, o_misaligned, o_bus_err;

    rv32i_memory_stage #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_mem_op(i_mem_op), .i_funct3(i_funct3), .i_alu_result(i_alu_result),
        .i_store_data(i_store_data), .i_rd_addr(i_rd_addr), .i_rd_wr(i_rd_wr),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_gnt(i_dmem_gnt),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata), .o_valid(o_valid),
        .o_rf_wr_data(o_rf_wr_data), .o_rf_wr_addr(o_rf_wr_addr), .o_rf_wr_en(o_rf_wr_en),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk;
        logic        mis;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every writeback pulse must match the oldest expected result
    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) check("valid_without_op", {31'b0, o_valid}, 32'd0);
            else begin
                mon_e = sb.pop_front();
                check("rf_wr_en", {31'b0, o_rf_wr_en}, {31'b0, mon_e.en});
                check("rf_wr_addr", {27'b0, o_rf_wr_addr}, {27'b0, mon_e.addr});
                if (mon_e.chk) check("rf_wr_data", o_rf_wr_data, mon_e.data);
                check("misaligned", {31'b0, o_misaligned}, {31'b0, mon_e.mis});
                check("bus_err", {31'b0, o_bus_err}, {31'b0, mon_e.err});
                check("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready) check("ready_timeout", {31'b0, o_ready}, 32'd1);
    endtask

    task automatic accept(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] alu, sd,
                          input logic [4:0] rd, input logic rdw);
        wait_ready();
        i_valid = 1'b1; i_mem_op = op; i_funct3 = f3; i_alu_result = alu;
        i_store_data = sd; i_rd_addr = rd; i_rd_wr = rdw;
        @(posedge clk); #1;
        i_valid = 1'b0; i_mem_op = 2'($urandom); i_funct3 = 3'($urandom);
        i_alu_result = $urandom; i_store_data = $urandom; i_rd_addr = 5'($urandom);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] alu, sd,
                         input logic [4:0] rd, input logic rdw, input logic [31:0] rdata,
                         input int gw, input int rw);
        int size, off, lat;
        logic isld, isst, mis;
        logic [31:0] v, be, wd;
        exp_t e;
        isld = op == 2'd1;
        isst = op == 2'd2;
        size = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        off  = int'(alu % 4);
        mis  = (isld || isst) && (alu % size) != 0;
        v = alu;
        if (isld && !mis) begin
            v = rdata >> (8 * off);
            if (size == 1) v = f3[2] ? v & 32'hFF : {{24{v[7]}}, v[7:0]};
            else if (size == 2) v = f3[2] ? v & 32'hFFFF : {{16{v[15]}}, v[15:0]};
        end
        be = (size == 1 ? 32'd1 : size == 2 ? 32'd3 : 32'd15) << off;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % size) +: 8];
        e.en   = !isst && !mis && rdw && rd != 5'd0;
        e.addr = rd;
        e.data = rd == 5'd0 ? 32'd0 : v;
        e.chk  = e.en || rd == 5'd0;
        e.mis  = mis;
        e.err  = 1'b0;
        lat = (isld || isst) && !mis ? (isst ? gw + 2 : gw + rw + 3) : 1;
        accept(op, f3, alu, sd, rd, rdw);
        e.cyc = cyc + lat - 1;
        sb.push_back(e);
        if ((isld || isst) && !mis) begin
            for (int k = 0; k <= gw; k++) begin
                check("dmem_req", {31'b0, o_dmem_req}, 32'd1);
                check("dmem_addr", o_dmem_addr, alu & ~32'd3);
                check("dmem_be", {28'b0, o_dmem_be}, be);
                check("dmem_we", {31'b0, o_dmem_we}, {31'b0, isst});
                check("dmem_wdata", o_dmem_wdata, isst ? wd : 32'd0);
                i_dmem_gnt = k == gw;
                i_dmem_rvalid = 1'($urandom);
                i_dmem_rdata = $urandom;
                @(posedge clk); #1;
            end
            i_dmem_gnt = 1'b0;
            i_dmem_rvalid = 1'b0;
            if (isld) begin
                for (int k = 0; k <= rw; k++) begin
                    check("req_dropped_in_wait", {31'b0, o_dmem_req}, 32'd0);
                    i_dmem_rvalid = k == rw;
                    i_dmem_rdata = k == rw ? rdata : $urandom;
                    @(posedge clk); #1;
                end
                i_dmem_rvalid = 1'b0;
            end
        end else check("no_req", {31'b0, o_dmem_req}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [1:0] op;
        i_rst = 1'b1; i_valid = 1'b0; i_mem_op = '0; i_funct3 = '0; i_alu_result = '0;
        i_store_data = '0; i_rd_addr = '0; i_rd_wr = 1'b0; i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_req", {31'b0, o_dmem_req}, 32'd0);
        check("rst_be", {28'b0, o_dmem_be}, 32'd0);
        check("rst_wdata", o_dmem_wdata, 32'd0);
        check("rst_wr_en", {31'b0, o_rf_wr_en}, 32'd0);
        check("rst_wr_data", o_rf_wr_data, 32'd0);
        check("rst_bus_err", {31'b0, o_bus_err}, 32'd0);
        i_rst = 1'b0;

        issue(2'd1, 3'b000, 32'h1003, 32'h0, 5'd5, 1'b1, 32'h8000_0000, 0, 0);
        issue(2'd1, 3'b101, 32'h2002, 32'h0, 5'd6, 1'b1, 32'hBEEF_1234, 0, 0);
        issue(2'd1, 3'b001, 32'h2002, 32'h0, 5'd6, 1'b1, 32'hBEEF_1234, 1, 2);
        issue(2'd2, 3'b000, 32'h10, 32'hA5, 5'd7, 1'b1, 32'h0, 4, 0);
        issue(2'd2, 3'b010, 32'h6, 32'h1234_5678, 5'd8, 1'b1, 32'h0, 0, 0);
        issue(2'd0, 3'b000, 32'h55, 32'h0, 5'd0, 1'b1, 32'h0, 0, 0);
        issue(2'd3, 3'b010, 32'h77, 32'h0, 5'd9, 1'b1, 32'h0, 0, 0);
        issue(2'd1, 3'b110, 32'h40, 32'h0, 5'd10, 1'b1, 32'hCAFE_F00D, 2, 1);

        repeat (200) begin
            op = 2'($urandom);
            issue(op, op == 2'd2 ? 3'($urandom_range(0, 2)) : 3'($urandom), $urandom, $urandom,
                  $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        accept(2'd1, 3'b010, 32'h100, 32'h0, 5'd4, 1'b1);
        i_dmem_gnt = 1'b1;
        @(posedge clk); #1;
        i_dmem_gnt = 1'b0;
        i_rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", {31'b0, o_ready}, 32'd1);
        check("midrst_req", {31'b0, o_dmem_req}, 32'd0);
        check("midrst_valid", {31'b0, o_valid}, 32'd0);
        check("midrst_wr_data", o_rf_wr_data, 32'd0);
        i_rst = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        i_dmem_rvalid = 1'b0;
        check("late_rvalid_ready", {31'b0, o_ready}, 32'd1);
        check("late_rvalid_valid", {31'b0, o_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        accept(2'd1, 3'b010, 32'h200, 32'h0, 5'd3, 1'b1);
`ifdef DMEM_TIMEOUT_EN
        e.en = 1'b0; e.addr = 5'd3; e.data = 32'd0; e.chk = 1'b0; e.mis = 1'b0; e.err = 1'b1;
        e.cyc = cyc + 8;
        sb.push_back(e);
        wait_ready();
`else
        repeat (100) @(posedge clk);
        #1;
        check("stall_req_held", {31'b0, o_dmem_req}, 32'd1);
        check("stall_no_valid", {31'b0, o_valid}, 32'd0);
        check("stall_no_bus_err", {31'b0, o_bus_err}, 32'd0);
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
